// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings OP_ADD .. OP_SAR (4'b1111 is deliberately left unnamed: invalid)
//   - FSM state encoding for seq_alu
//   - is_iterative(): opcodes that use the multi-cycle engine
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1000;
   localparam logic [3:0] OP_SHL = 4'b1001;
   localparam logic [3:0] OP_SHR = 4'b1010;
   localparam logic [3:0] OP_EQ  = 4'b1011;
   localparam logic [3:0] OP_GT  = 4'b1100;
   localparam logic [3:0] OP_LT  = 4'b1101;
   localparam logic [3:0] OP_SAR = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // True for ops that can run on the shift-add / restoring engine.
   // DIV/MOD by zero is still short-circuited by the caller.
   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned engine working on operand magnitudes.
//   Multiply: shift-add, N iterations, product in {hi, lo}.
//   Divide  : restoring, N iterations, quotient in lo, remainder in hi.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   go              load mag_a/mag_b and start N iterations
//   is_div          1 = divide, 0 = multiply (sampled with go)
//   mag_a, mag_b    unsigned magnitudes (multiplicand/multiplier or dividend/divisor)
//   done            high during the cycle whose edge performs the last iteration
//   prod            2N-bit product
//   quo, rem        N-bit quotient and remainder
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           go,
   input  logic           is_div,
   input  logic [N-1:0]   mag_a,
   input  logic [N-1:0]   mag_b,
   output logic           done,
   output logic [2*N-1:0] prod,
   output logic [N-1:0]   quo,
   output logic [N-1:0]   rem
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // hi holds the partial product / running remainder, lo the multiplier /
   // dividend being shifted out while quotient bits shift in.
   logic [N-1:0]  hi_q, hi_d;
   logic [N-1:0]  lo_q, lo_d;
   logic [N-1:0]  opb_q, opb_d;
   logic          div_q, div_d;
   logic          act_q, act_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N:0]    add_sum;
   logic [N:0]    shl_rem;
   logic [N-1:0]  trial;
   logic          take;

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      opb_d = opb_q;
      div_d = div_q;
      act_d = act_q;
      cnt_d = cnt_q;

      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      shl_rem = {hi_q, lo_q[N-1]};
      take    = (shl_rem >= {1'b0, opb_q});
      // Only used when take=1, where the true difference is < divisor and
      // therefore fits in N bits.
      trial   = shl_rem[N-1:0] - opb_q;

      if (go) begin
         hi_d  = '0;
         lo_d  = mag_a;
         opb_d = mag_b;
         div_d = is_div;
         act_d = 1'b1;
         cnt_d = '0;
      end else if (act_q) begin
         if (div_q) begin
            hi_d = take ? trial : shl_rem[N-1:0];
            lo_d = {lo_q[N-2:0], take};
         end else begin
            hi_d = add_sum[N:1];
            lo_d = {add_sum[0], lo_q[N-1:1]};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            act_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
         act_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         opb_q <= opb_d;
         div_q <= div_d;
         act_q <= act_d;
         cnt_q <= cnt_d;
      end
   end

   assign done = act_q && (cnt_q == LAST);
   assign prod = {hi_q, lo_q};
   assign quo  = lo_q;
   assign rem  = hi_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/busy/ready handshake.
//   Single-cycle ops complete on the accepting edge; MUL/DIV/MOD run on
//   seq_muldiv and complete N+2 edges after acceptance. Flags are
//   registered together with result and only change on completion.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, opcode, a, b request (accepted only when busy=0)
//   busy                iterative op in flight
//   ready               one-cycle completion pulse
//   result              2N-bit registered result
//   z, c, v, s, e       zero, carry/borrow, overflow, sign, error flags
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting requests; single-cycle ops complete here
// ST_ITER | engine iterating (N edges)
// ST_DONE | sign-correct engine output, register result/flags, pulse ready
module seq_alu
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [3:0]     opcode,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           ready,
   output logic [2*N-1:0] result,
   output logic           z,
   output logic           c,
   output logic           v,
   output logic           s,
   output logic           e
);

   localparam int W   = 2 * N;
   localparam int SHW = $clog2(N);

   state_e       state_q, state_d;
   logic         busy_q, busy_d;
   logic         ready_q, ready_d;
   logic [W-1:0] result_q, result_d;
   logic         z_q, z_d, c_q, c_d, v_q, v_d, s_q, s_d, e_q, e_d;
   logic [3:0]   op_q, op_d;
   logic         sa_q, sa_d, sb_q, sb_d;

   logic         iter_req;
   logic         md_go;
   logic [N-1:0] mag_a, mag_b;
   logic         md_done;
   logic [W-1:0] md_prod;
   logic [N-1:0] md_quo, md_rem;

   // DIV/MOD by zero never enters the engine; it completes as an error.
   assign iter_req = is_iterative(opcode) && !((opcode != OP_MUL) && (b == '0));
   assign md_go    = (state_q == ST_IDLE) && start && iter_req;
   assign mag_a    = a[N-1] ? (-a) : a;
   assign mag_b    = b[N-1] ? (-b) : b;

   seq_muldiv #(.N(N)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .go     (md_go),
      .is_div (opcode != OP_MUL),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .done   (md_done),
      .prod   (md_prod),
      .quo    (md_quo),
      .rem    (md_rem)
   );

   // Single-cycle datapath.
   logic [N:0]     sum_ext, diff_ext;
   logic [SHW-1:0] amt;
   logic [N-1:0]   sar_n;
   logic [W-1:0]   sc_res;
   logic           sc_c, sc_v, sc_e;

   always_comb begin
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      amt      = b[SHW-1:0];
      sar_n    = $signed(a) >>> amt;
      sc_res   = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      sc_e     = 1'b0;
      case (opcode)
         OP_ADD: begin
            sc_res = {{N{sum_ext[N-1]}}, sum_ext[N-1:0]};
            sc_c   = sum_ext[N];
            sc_v   = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
         end
         OP_SUB: begin
            sc_res = {{N{diff_ext[N-1]}}, diff_ext[N-1:0]};
            sc_c   = diff_ext[N];  // borrow == a < b unsigned
            sc_v   = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);
         end
         OP_AND: sc_res = {{N{1'b0}}, a & b};
         OP_OR:  sc_res = {{N{1'b0}}, a | b};
         OP_XOR: sc_res = {{N{1'b0}}, a ^ b};
         OP_NOT: sc_res = {{N{1'b0}}, ~a};
         OP_SHL: sc_res = {{N{1'b0}}, a << amt};
         OP_SHR: sc_res = {{N{1'b0}}, a >> amt};
         OP_SAR: sc_res = {{N{sar_n[N-1]}}, sar_n};
         OP_EQ:  sc_res[0] = (a == b);
         OP_GT:  sc_res[0] = ($signed(a) > $signed(b));
         OP_LT:  sc_res[0] = ($signed(a) < $signed(b));
         // Iterative opcodes only reach here as DIV/MOD by zero.
         OP_MUL, OP_DIV, OP_MOD: sc_e = 1'b1;
         default: sc_e = 1'b1;
      endcase
   end

   // Sign correction of the engine output.
   logic         neg;
   logic [W-1:0] prod_s;
   logic [N:0]   q_s, r_s;
   logic [W-1:0] it_res;
   logic         it_v;

   always_comb begin
      neg    = sa_q ^ sb_q;
      prod_s = neg ? (-md_prod) : md_prod;
      // N+1 bits: a positive quotient of 2^(N-1) must survive.
      q_s    = neg ? (-{1'b0, md_quo}) : {1'b0, md_quo};
      r_s    = sa_q ? (-{1'b0, md_rem}) : {1'b0, md_rem};
      if (op_q == OP_MUL) begin
         it_res = prod_s;
      end else if (op_q == OP_DIV) begin
         it_res = {{(N-1){q_s[N]}}, q_s};
      end else begin
         it_res = {{(N-1){r_s[N]}}, r_s};
      end
      // The only positive quotient with the top magnitude bit set is
      // most-negative / -1.
      it_v = (op_q == OP_DIV) && !neg && md_quo[N-1];
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      ready_d  = 1'b0;
      result_d = result_q;
      z_d      = z_q;
      c_d      = c_q;
      v_d      = v_q;
      s_d      = s_q;
      e_d      = e_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (iter_req) begin
                  op_d    = opcode;
                  sa_d    = a[N-1];
                  sb_d    = b[N-1];
                  busy_d  = 1'b1;
                  state_d = ST_ITER;
               end else begin
                  result_d = sc_res;
                  z_d      = (sc_res == '0);
                  s_d      = sc_res[W-1];
                  c_d      = sc_c;
                  v_d      = sc_v;
                  e_d      = sc_e;
                  ready_d  = 1'b1;
               end
            end
         end
         ST_ITER: begin
            if (md_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            result_d = it_res;
            z_d      = (it_res == '0);
            s_d      = it_res[W-1];
            c_d      = 1'b0;
            v_d      = it_v;
            e_d      = 1'b0;
            ready_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         s_q      <= 1'b0;
         e_q      <= 1'b0;
         op_q     <= OP_ADD;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         result_q <= result_d;
         z_q      <= z_d;
         c_q      <= c_d;
         v_q      <= v_d;
         s_q      <= s_d;
         e_q      <= e_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
      end
   end

   assign busy   = busy_q;
   assign ready  = ready_q;
   assign result = result_q;
   assign z      = z_q;
   assign c      = c_q;
   assign v      = v_q;
   assign s      = s_q;
   assign e      = e_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
   import alu_pkg::*;

   localparam int N = 8;
   localparam int W = 2 * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   opcode = 4'd0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         busy, ready;
   logic [W-1:0] result;
   logic         z, c, v, s, e;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .opcode (opcode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .ready  (ready),
      .result (result),
      .z      (z),
      .c      (c),
      .v      (v),
      .s      (s),
      .e      (e)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge. Issues one request, waits (bounded) for ready.
   // poke_at > 0 pulses an extra ADD start that many cycles in.
   task automatic run_op(input logic [3:0] op, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input int poke_at, output int lat_o, output int busy_o);
      start  = 1'b1;
      opcode = op;
      a      = av;
      b      = bv;
      lat_o  = 0;
      busy_o = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat_o++;
         if (busy) busy_o++;
         if (lat_o == poke_at && !ready) begin
            start  = 1'b1;
            opcode = OP_ADD;
            a      = 8'd1;
            b      = 8'd1;
         end
      end while (!ready && lat_o < 40);
      start = 1'b0;
      check("ready_seen", 32'(ready), 32'd1);
   endtask

   // Flags packed as {z,c,v,s,e}.
   task automatic do_chk(input string tag, input logic [3:0] op, input logic [N-1:0] av,
                         input logic [N-1:0] bv, input logic [W-1:0] exp_res,
                         input logic [4:0] exp_fl, input int exp_lat);
      int l;
      int bc;
      run_op(op, av, bv, 0, l, bc);
      check({tag, "_res"}, 32'(result), 32'(exp_res));
      check({tag, "_flags"}, 32'({z, c, v, s, e}), 32'(exp_fl));
      check({tag, "_lat"}, 32'(l), 32'(exp_lat));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l;
      int bc;
      int extra;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_ready",  32'(ready),  32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags",  32'({z, c, v, s, e}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Add/sub, including back-to-back issue in the ready cycle.
      do_chk("add_ovf",  OP_ADD, 8'd127, 8'd1,  16'hFF80, 5'b00110, 1);
      @(negedge clk);
      do_chk("sub_brw",  OP_SUB, 8'd0,   8'd1,  16'hFFFF, 5'b01010, 1);
      do_chk("add_b2b",  OP_ADD, 8'hFF,  8'd1,  16'h0000, 5'b11000, 1);
      do_chk("add_negov",OP_ADD, 8'h80,  8'h80, 16'h0000, 5'b11100, 1);
      do_chk("sub_ovf",  OP_SUB, 8'h80,  8'h01, 16'h007F, 5'b00100, 1);

      // Logic, shifts, compares.
      do_chk("and",  OP_AND, 8'hF0, 8'h3C, 16'h0030, 5'b00000, 1);
      do_chk("or",   OP_OR,  8'h01, 8'h80, 16'h0081, 5'b00000, 1);
      do_chk("xor",  OP_XOR, 8'hAA, 8'hFF, 16'h0055, 5'b00000, 1);
      do_chk("not",  OP_NOT, 8'h0F, 8'h00, 16'h00F0, 5'b00000, 1);
      do_chk("shl",  OP_SHL, 8'h81, 8'h09, 16'h0002, 5'b00000, 1);
      do_chk("shr",  OP_SHR, 8'h80, 8'h03, 16'h0010, 5'b00000, 1);
      do_chk("sar",  OP_SAR, 8'h80, 8'h03, 16'hFFF0, 5'b00010, 1);
      do_chk("eq",   OP_EQ,  8'h05, 8'h05, 16'h0001, 5'b00000, 1);
      do_chk("gt",   OP_GT,  8'h03, 8'hFE, 16'h0001, 5'b00000, 1);
      do_chk("lt_f", OP_LT,  8'h03, 8'hFE, 16'h0000, 5'b10000, 1);
      do_chk("gt_f", OP_GT,  8'h80, 8'h7F, 16'h0000, 5'b10000, 1);

      // MUL with an ignored mid-op start; exactly one ready.
      @(negedge clk);
      run_op(OP_MUL, 8'hF9, 8'd6, 3, l, bc);
      check("mul_res",  32'(result), 32'h0000FFD6);
      check("mul_flags",32'({z, c, v, s, e}), 32'b00010);
      check("mul_lat",  32'(l),  32'd10);
      check("mul_busy", 32'(bc), 32'd9);
      extra = 0;
      repeat (14) begin
         @(negedge clk);
         if (ready) extra++;
      end
      check("mul_one_ready", 32'(extra), 32'd0);
      check("mul_held", 32'(result), 32'h0000FFD6);

      do_chk("mul_mix",  OP_MUL, 8'h7F, 8'h80, 16'hC080, 5'b00010, 10);
      do_chk("mul_min2", OP_MUL, 8'h80, 8'h80, 16'h4000, 5'b00000, 10);
      do_chk("mul_zero", OP_MUL, 8'h00, 8'h05, 16'h0000, 5'b10000, 10);
      do_chk("div_neg",  OP_DIV, 8'hF9, 8'd2,  16'hFFFD, 5'b00010, 10);
      do_chk("mod_neg",  OP_MOD, 8'hF9, 8'd2,  16'hFFFF, 5'b00010, 10);
      do_chk("div_ovf",  OP_DIV, 8'h80, 8'hFF, 16'h0080, 5'b00100, 10);
      do_chk("div_nb",   OP_DIV, 8'h07, 8'hFE, 16'hFFFD, 5'b00010, 10);
      do_chk("mod_nb",   OP_MOD, 8'h07, 8'hFE, 16'h0001, 5'b00000, 10);

      // Divide by zero and invalid opcode: single cycle, error, no busy.
      @(negedge clk);
      run_op(OP_DIV, 8'd5, 8'd0, 0, l, bc);
      check("div0_res",  32'(result), 32'd0);
      check("div0_flags",32'({z, c, v, s, e}), 32'b10001);
      check("div0_lat",  32'(l),  32'd1);
      check("div0_busy", 32'(bc), 32'd0);
      do_chk("mod0",  OP_MOD, 8'h80, 8'h00, 16'h0000, 5'b10001, 1);
      do_chk("inval", 4'b1111, 8'd3, 8'd4,  16'h0000, 5'b10001, 1);

      // Establish a nonzero result, then reset 4 cycles into a MUL.
      do_chk("pre_rst", OP_XOR, 8'h0F, 8'hF0, 16'h00FF, 5'b00000, 1);
      @(negedge clk);
      start  = 1'b1;
      opcode = OP_MUL;
      a      = 8'hF9;
      b      = 8'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy",   32'(busy),   32'd0);
      check("rst_mid_ready",  32'(ready),  32'd0);
      check("rst_mid_result", 32'(result), 32'd0);
      check("rst_mid_flags",  32'({z, c, v, s, e}), 32'd0);
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (ready || busy) extra++;
      end
      check("rst_mid_no_ready", 32'(extra), 32'd0);
      do_chk("post_rst_add", OP_ADD, 8'd2, 8'd3, 16'h0005, 5'b00000, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the team's single-cycle ALU.
- Single-cycle arithmetic, logic, shift and compare ops complete in one clock.
- MUL, DIV and MOD run on an iterative shift-add / restoring engine: N iterations, no wide combinational multiplier or divider.
- Sits between the control FSM and the register file. Uses a start/busy/ready handshake, and its flags are registered together with the result.

Parameters:
- N, 8: operand width in bits, N >= 4. The result is 2N bits wide.
- SHW, $clog2(N): number of B bits used as the shift amount (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  request; accepted on a rising edge only when busy=0.
- opcode  in  4  operation select; sampled with start.
- a  in  N  operand A, signed two's complement.
- b  in  N  operand B, signed two's complement.
- busy  out  1  high while an iterative op is in flight.
- ready  out  1  one-cycle pulse; result and flags are valid and complete.
- result  out  2N  registered result; held until the next completion.
- z  out  1  result == 0.
- c  out  1  carry (ADD) or borrow (SUB); 0 for all other ops.
- v  out  1  signed overflow: ADD/SUB N-bit overflow, or DIV of the most-negative value by -1.
- s  out  1  result[2N-1].
- e  out  1  error: divide/mod by zero, or invalid opcode.

Behaviour:
- Reset:
  - Applies on any clock edge with rst=1, including mid-operation.
  - busy, ready, result and all flags go to 0; the FSM goes to IDLE.
  - Any in-flight operation is discarded and no ready pulse is issued for it.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - On start=1 with a single-cycle opcode, or with DIV/MOD and b==0: result and flags are registered on that edge, ready=1 for the next cycle, and the FSM stays in IDLE. Latency is 1.
  - On start=1 with MUL, or with DIV/MOD and b!=0: a and b are latched as magnitudes plus sign bits, busy goes to 1, the iteration counter is cleared, and the FSM goes to ITER.
- ITER:
  - Performs exactly N iterations, one per edge.
  - Then moves to DONE.
- DONE:
  - Applies the sign correction, then registers result and flags.
  - ready=1 for one cycle, busy=0, FSM returns to IDLE.
  - Total latency is N+2 edges from acceptance; busy is high for N+1 cycles.
- start while busy=1 is ignored and never queued.
- start in the same cycle as ready=1 is accepted, so back-to-back operation is legal.
- Opcodes:
  - 0000 ADD, 0001 SUB: result = N-bit wrapped sum/difference, sign-extended to 2N. c = unsigned carry-out (ADD) or a<b unsigned (SUB). v is computed from the true operand signs.
  - 0010 MUL: full 2N-bit signed product.
  - 0011 DIV: quotient truncated toward zero, sign-extended to 2N.
  - 0100 MOD: remainder takes the sign of the dividend.
  - DIV/MOD with b==0: result=0, e=1.
  - DIV with -2^(N-1) / -1: result = +2^(N-1) in 2N bits, v=1.
  - 0101 AND, 0110 OR, 0111 XOR, 1000 NOT A: N-bit result, zero-extended.
  - 1001 SHL: N-bit result. 1010 SHR: logical, N-bit result. 1110 SAR: arithmetic, sign-extended to 2N. All shifts use b[SHW-1:0] as the amount.
  - 1011 EQ, 1100 GT, 1101 LT: signed compare; result = 1 or 0.
  - 1111 (invalid): result=0, e=1, latency 1.
- Flag timing:
  - z and s are derived from the value being written to result, not from the previous registered result. All flags change only on completion.
  - Flags not defined for an op are driven to 0.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams OP_ADD .. OP_SAR;
  - the FSM state encoding;
  - the function is_iterative(opcode).
- Sub-module seq_muldiv (parameter N) holds the iterative engine: shift-add multiply and restoring unsigned divide on magnitudes.
  - Interface: go, is_div, mag_a, mag_b -> done, prod[2N-1:0], quo[N-1:0], rem[N-1:0].
  - The top level does the sign handling and owns the flags.

Test Plan (N=8):
- ADD a=127, b=1 -> one cycle later ready=1, result=16'hFF80, v=1, c=0, s=1, z=0.
- SUB a=0, b=1 -> result=16'hFFFF, c=1, v=0. Then back-to-back ADD a=-1, b=1 issued in the ready cycle -> result=0, z=1, c=1.
- MUL a=-7, b=6 -> busy high 9 cycles, ready exactly 10 edges after acceptance, result=16'hFFD6. A start pulsed mid-op is ignored and gives exactly one ready.
- DIV a=-7, b=2 -> result=16'hFFFD. MOD a=-7, b=2 -> result=16'hFFFF. DIV a=-128, b=-1 -> result=16'h0080, v=1.
- DIV a=5, b=0 -> 1-cycle latency, result=0, e=1, busy never asserts. Opcode 1111 -> e=1.
- Reset asserted 4 cycles into a MUL -> next cycle busy=0, result=0, all flags 0, no ready pulse. A following ADD 2+3 gives result=5.
